// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Boot-time loader for the RV32I core. Accepts a program as a byte stream
//   over a valid/ready handshake. It assembles little-endian 32-bit words and
//   writes each one into instruction memory through a one-cycle write port.
//   The core is held in reset until the last word of the image is written.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_start        one-cycle pulse that begins a load (honoured in IDLE/RUN/ERROR)
//   i_word_count   number of words to load, latched on an accepted start
//   i_byte_valid   i_byte_data carries a valid byte
//   i_byte_data    program byte, least-significant byte of each word first
//   o_byte_ready   loader accepts a byte this cycle
//   o_imem_we      instruction-memory write strobe, one cycle per word
//   o_imem_addr    word-aligned byte address of the word being written
//   o_imem_wdata   assembled word
//   o_core_reset   reset to the core, high except in RUN
//   o_busy         load in progress (LOAD or WRITE)
//   o_done         image loaded, core running
//   o_error        last start carried an illegal word count
module imem_program_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte_data,
  output logic             o_byte_ready,
  output logic             o_imem_we,
  output logic [31:0]      o_imem_addr,
  output logic [31:0]      o_imem_wdata,
  output logic             o_core_reset,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam int WI_W = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WI_W-1:0]  r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_buf;      // lanes 0..2; lane 3 goes straight to r_wdata
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic w_start_ok;
  logic w_count_bad;
  logic w_accept;
  logic w_last_lane;
  logic w_last_word;

  // start is only honoured outside an active load
  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_RUN) ||
                                   (r_state == S_ERROR));
  assign w_count_bad = (i_word_count == '0) || (i_word_count > DEPTH_C);
  assign w_accept    = (r_state == S_LOAD) && i_byte_valid;
  assign w_last_lane = (r_byte_idx == 2'd3);
  assign w_last_word = (CNT_W'(r_word_idx) == (r_count - CNT_W'(1)));

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_start_ok) begin
          w_state_next = w_count_bad ? S_ERROR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_lane) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_next = w_last_word ? S_RUN : S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only
  always_comb begin
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_core_reset = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
      end
      S_RUN: begin
        o_core_reset = 1'b0;
        o_done       = 1'b1;
      end
      S_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end

  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_count    <= i_word_count;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end
      if (w_accept) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        // Address/data are captured one cycle ahead of the strobe so they are
        // stable during WRITE and simply hold afterwards.
        if (w_last_lane) begin
          r_wdata <= {i_byte_data, r_buf};
          r_addr  <= 32'(r_word_idx) << 2;
        end
      end
      if ((r_state == S_WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + WI_W'(1);
      end
    end
  end

  // Byte lanes 0..2 of the word being assembled
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_buf[8*gi +: 8] <= '0;
        end else if (w_accept && (r_byte_idx == 2'(gi))) begin
          r_buf[8*gi +: 8] <= i_byte_data;
        end
      end
    end
  endgenerate

endmodule
